lbi_bridge: RTL
===============

LBI_BRIDGE -- requirements
Module: lbi_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2; number of synchronizer flops on each CPU strobe (legal 2..4).
REQ-002 Parameter TIMEOUT_CYC, default 255; hold-phase timeout in clk cycles (legal 1..65535), used only with LBI_TIMEOUT_EN.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cs_n, we_n, oe_n  in  1 each  CPU local-bus strobes, asynchronous to clk, active-low.
REQ-006 cpu_addr  in  22  CPU word address (A30/A31 excluded); stable while cs_n low.
REQ-007 cpu_wdata  in  32  CPU write data; stable while we_n low.
REQ-008 cpu_rdata  out  32  registered read data returned to the CPU.
REQ-009 cpu_data_oe  out  1  drive enable for the CPU data pad.
REQ-010 ta_n  out  1  transfer acknowledge to the CPU, active-low.
REQ-011 addr  out  22, we out 1, re out 1, write_data out 32: register-file access port, all registered.
REQ-012 read_data  in  32  register-file read data, valid in the cycle re=1.
REQ-013 bus_err  out  1  one-cycle pulse on hold-phase timeout (tied 0 without LBI_TIMEOUT_EN).

Function
REQ-014 cs_n, we_n and oe_n SHALL each pass through SYNC_STAGES flops before use; cpu_addr/cpu_wdata SHALL be sampled only on the FSM decision edge.
REQ-015 The FSM SHALL have states IDLE, WR, RD, CAP, HOLD, plus ERR when LBI_TIMEOUT_EN is defined.
REQ-016 IDLE: on an edge N with armed=1, sync cs_n=0 and sync we_n=0, SHALL latch addr<=cpu_addr and write_data<=cpu_wdata and go to WR.
REQ-017 IDLE: on an edge N with armed=1, sync cs_n=0, sync oe_n=0 and sync we_n=1, SHALL latch addr<=cpu_addr and go to RD.
REQ-018 we and oe_n both low SHALL be treated as a write; read SHALL NOT occur.
REQ-019 WR: we=1 for exactly the cycle after edge N; next state HOLD.
REQ-020 RD: re=1 for exactly the cycle after edge N; cpu_rdata<=read_data at edge N+2; next state CAP, then HOLD.
REQ-021 we and re SHALL never be high together and SHALL each be high at most one cycle per CPU access.
REQ-022 ta_n SHALL be 0 from the cycle after edge N+1 (write) or edge N+2 (read) while in HOLD; 1 otherwise.
REQ-023 cpu_data_oe SHALL be 1 only in HOLD of a read access while sync oe_n=0.
REQ-024 HOLD: when sync cs_n=1, go to IDLE, with ta_n=1 and cpu_data_oe=0 from the next cycle.
REQ-025 armed SHALL clear on any access start and set only when sync cs_n=1 is seen in IDLE; a cs_n held low SHALL produce no second access.
REQ-026 addr and write_data SHALL hold their last values between accesses; cpu_rdata SHALL hold until the next read.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, armed=0, synchronizers to 1, we=0, re=0, ta_n=1, cpu_data_oe=0, bus_err=0, addr=0, write_data=0, cpu_rdata=0, timeout counter=0.
REQ-028 Reset mid-access SHALL abort it with no we/re pulse afterwards until cs_n is seen high and then low again.

Configuration
REQ-029 Macro LBI_TIMEOUT_EN defined: a 16-bit counter SHALL run in HOLD; after TIMEOUT_CYC cycles with sync cs_n still 0 -> bus_err=1 for one cycle, ta_n=1, cpu_data_oe=0, state ERR; ERR exits to IDLE on sync cs_n=1.
REQ-030 LBI_TIMEOUT_EN undefined: no counter, no ERR state, bus_err tied 0, HOLD waits indefinitely.

Verification
REQ-031 Write cpu_addr=22'h0006, cpu_wdata=32'h000000A5 -> one we pulse, addr=22'h0006, write_data=32'h000000A5, ta_n low until cs_n high.
REQ-032 Read addr 22'h0003 with read_data=32'h12345678 in the re cycle -> single re pulse, cpu_rdata=32'h12345678, cpu_data_oe=1 while oe_n low.
REQ-033 cs_n held low 100 cycles after a read -> exactly one re pulse; a new access only after cs_n high then low.
REQ-034 we_n and oe_n both low, addr 22'h0000 -> we=1 once, re never asserted.
REQ-035 rst_n low during HOLD of a write -> ta_n=1, we=0 immediately; cs_n still low after release -> no access.
REQ-036 LBI_TIMEOUT_EN, TIMEOUT_CYC=10, cs_n held low -> bus_err single pulse 10 cycles into HOLD, ta_n=1, then IDLE after cs_n high.

Source files
------------

// File: rtl/lbi_bridge.sv
// CPU local-bus to register-file bridge: synchronises async strobes, issues one we/re pulse
// per access and holds ta_n low until cs_n releases. Optional macro: LBI_TIMEOUT_EN.
module lbi_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        we_n,
    input  logic        oe_n,
    input  logic [21:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_data_oe,
    output logic        ta_n,
    output logic [21:0] addr,
    output logic        we,
    output logic        re,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        bus_err
);

`ifdef LBI_TIMEOUT_EN
    typedef enum logic [2:0] {StIdle, StWr, StRd, StCap, StHold, StErr} state_e;
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);
`else
    typedef enum logic [2:0] {StIdle, StWr, StRd, StCap, StHold} state_e;
`endif

    logic [SYNC_STAGES-1:0] cs_sync_q, we_sync_q, oe_sync_q, fill_q;
    logic                   cs_s, we_s, oe_s, sync_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q <= '1;
            we_sync_q <= '1;
            oe_sync_q <= '1;
            fill_q    <= '0;
        end else begin
            cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], we_n};
            oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], oe_n};
            fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign cs_s = cs_sync_q[SYNC_STAGES-1];
    assign we_s = we_sync_q[SYNC_STAGES-1];
    assign oe_s = oe_sync_q[SYNC_STAGES-1];
    // The reset value of the chain is not a real cs_n=1 sample; arming waits until it has flushed.
    assign sync_ok = fill_q[SYNC_STAGES-1];

    state_e      state_q, state_d;
    logic        armed_q, armed_d;
    logic        rd_acc_q, rd_acc_d;
    logic [21:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_hold_q, rd_hold_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_q, we_d, re_q, re_d;
    logic        ta_n_q, ta_n_d, oe_q, oe_d, err_q, err_d;
`ifdef LBI_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        rd_acc_d  = rd_acc_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_hold_d = rd_hold_q;
        rdata_d   = rdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
`ifdef LBI_TIMEOUT_EN
        cnt_d     = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!armed_q) begin
                    if (cs_s && sync_ok) armed_d = 1'b1;
                end else if (!cs_s) begin
                    // we_n wins over oe_n so a both-low cycle is a write only.
                    if (!we_s) begin
                        state_d  = StWr;
                        we_d     = 1'b1;
                        addr_d   = cpu_addr;
                        wdata_d  = cpu_wdata;
                        armed_d  = 1'b0;
                        rd_acc_d = 1'b0;
                    end else if (!oe_s) begin
                        state_d  = StRd;
                        re_d     = 1'b1;
                        addr_d   = cpu_addr;
                        armed_d  = 1'b0;
                        rd_acc_d = 1'b1;
                    end
                end
            end
            StWr: state_d = StHold;
            StRd: begin
                rd_hold_d = read_data;
                state_d   = StCap;
            end
            StCap: begin
                rdata_d = rd_hold_q;
                state_d = StHold;
            end
            StHold: begin
                if (cs_s) begin
                    state_d = StIdle;
`ifdef LBI_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
`ifdef LBI_TIMEOUT_EN
            StErr: if (cs_s) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase

        ta_n_d = (state_d != StHold);
        oe_d   = (state_d == StHold) && rd_acc_d && !oe_s;
`ifdef LBI_TIMEOUT_EN
        err_d  = (state_q == StHold) && (state_d == StErr);
`else
        err_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            armed_q   <= 1'b0;
            rd_acc_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_hold_q <= '0;
            rdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            ta_n_q    <= 1'b1;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            rd_acc_q  <= rd_acc_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_hold_q <= rd_hold_d;
            rdata_q   <= rdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            ta_n_q    <= ta_n_d;
            oe_q      <= oe_d;
            err_q     <= err_d;
        end
    end

`ifdef LBI_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign cpu_rdata   = rdata_q;
    assign cpu_data_oe = oe_q;
    assign ta_n        = ta_n_q;
    assign addr        = addr_q;
    assign we          = we_q;
    assign re          = re_q;
    assign write_data  = wdata_q;
    assign bus_err     = err_q;

endmodule
